// File: rtl/bsg_fpu_mul_arb_pkg.sv
// rtl/bsg_fpu_mul_arb_pkg.sv - shared types and helpers for the FP multiplier arbiter
package bsg_fpu_mul_arb_pkg;

    typedef struct packed {
        logic unimplemented;
        logic invalid;
        logic overflow;
        logic underflow;
    } fpu_flags_s;

    // Tag width must stay at least one bit even for a single requester.
    function automatic int tag_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/bsg_fpu_mul_arb_tag_fifo.sv
// rtl/bsg_fpu_mul_arb_tag_fifo.sv - circular tag FIFO with occupancy counter
module bsg_fpu_mul_arb_tag_fifo #(
    parameter int width_p = 2,
    parameter int els_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [width_p-1:0]         data_i,
    input  logic                       pop_i,
    output logic [width_p-1:0]         data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(els_p+1)-1:0] count_o
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p+1);

    logic [width_p-1:0]  mem [els_p];
    logic [ptr_w_lp-1:0] wptr_r;
    logic [ptr_w_lp-1:0] rptr_r;
    logic [cnt_w_lp-1:0] count_r;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_i) wptr_r <= ptr_inc(wptr_r);
            if (pop_i)  rptr_r <= ptr_inc(rptr_r);
            if (push_i && !pop_i)
                count_r <= count_r + 1'b1;
            else if (!push_i && pop_i)
                count_r <= count_r - 1'b1;
        end
    end

    // Storage needs no reset: contents are only read behind a non-empty count.
    always_ff @(posedge clk_i) begin
        if (push_i) mem[wptr_r] <= data_i;
    end

    assign data_o  = mem[rptr_r];
    assign full_o  = (count_r == cnt_w_lp'(els_p));
    assign empty_o = (count_r == '0);
    assign count_o = count_r;

endmodule

// File: rtl/bsg_fpu_mul_arbiter.sv
// rtl/bsg_fpu_mul_arbiter.sv - shares one pipelined FP multiplier among requesters
// Define BSG_FPU_MUL_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module bsg_fpu_mul_arbiter
    import bsg_fpu_mul_arb_pkg::*;
#(
    parameter int e_p       = 8,
    parameter int m_p       = 23,
    parameter int num_req_p = 4,
    parameter int tag_els_p = 4
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [num_req_p-1:0]                req_v_i,
    input  logic [num_req_p-1:0][e_p+m_p:0]     req_a_i,
    input  logic [num_req_p-1:0][e_p+m_p:0]     req_b_i,
    output logic [num_req_p-1:0]                req_ready_and_o,
    output logic [num_req_p-1:0]                resp_v_o,
    output logic [e_p+m_p:0]                    resp_z_o,
    output logic [3:0]                          resp_flags_o,
    input  logic [num_req_p-1:0]                resp_yumi_i,
    output logic                                mul_v_o,
    output logic [e_p+m_p:0]                    mul_a_o,
    output logic [e_p+m_p:0]                    mul_b_o,
    input  logic                                mul_ready_and_i,
    input  logic                                mul_v_i,
    input  logic [e_p+m_p:0]                    mul_z_i,
    input  logic [3:0]                          mul_flags_i,
    output logic                                mul_yumi_o,
    output logic [$clog2(tag_els_p+1)-1:0]      inflight_o
);

    localparam int tag_w_lp = tag_width(num_req_p);

    logic                tag_full;
    logic                tag_empty;
    logic [tag_w_lp-1:0] tag_head;
    logic [tag_w_lp-1:0] grant;
    logic                can_issue;
    logic                issue;
    logic                resp_ok;
    fpu_flags_s          flags;

    assign can_issue = mul_ready_and_i & ~tag_full & ~reset_i;
    assign issue     = can_issue & (|req_v_i);

`ifdef BSG_FPU_MUL_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = '0;
        for (int i = num_req_p-1; i >= 0; i--) begin
            if (req_v_i[i]) grant = tag_w_lp'(i);
        end
    end
`else
    logic [tag_w_lp-1:0] rr_ptr_r;

    // Search starts at the pointer and wraps; first valid requester wins.
    always_comb begin
        logic found;
        int   j;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < num_req_p; k++) begin
            j = int'(rr_ptr_r) + k;
            if (j >= num_req_p) j = j - num_req_p;
            if (!found && req_v_i[j]) begin
                grant = tag_w_lp'(j);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            rr_ptr_r <= '0;
        else if (issue)
            rr_ptr_r <= (int'(grant) == num_req_p-1) ? '0 : grant + 1'b1;
    end
`endif

    assign req_ready_and_o = issue ? (num_req_p'(1) << grant) : '0;
    assign mul_v_o         = issue;
    assign mul_a_o         = req_a_i[grant];
    assign mul_b_o         = req_b_i[grant];

    bsg_fpu_mul_arb_tag_fifo #(
        .width_p (tag_w_lp),
        .els_p   (tag_els_p)
    ) tag_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (issue),
        .data_i  (grant),
        .pop_i   (mul_yumi_o),
        .data_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (inflight_o)
    );

    // A result with no tag is a protocol error; keep it away from requesters.
    assign resp_ok      = mul_v_i & ~tag_empty & ~reset_i;
    assign resp_v_o     = resp_ok ? (num_req_p'(1) << tag_head) : '0;
    assign mul_yumi_o   = resp_ok & resp_yumi_i[tag_head];
    assign resp_z_o     = mul_z_i;
    assign flags        = fpu_flags_s'(mul_flags_i);
    assign resp_flags_o = flags;

    mul_v_needs_tag: assert property (@(posedge clk_i) disable iff (reset_i)
        !(mul_v_i && tag_empty));

endmodule

// File: tb/tb_bsg_fpu_mul_arbiter.sv
// tb/tb_bsg_fpu_mul_arbiter.sv - self-checking bench; honours BSG_FPU_MUL_ARB_FIXED_PRIO_EN
module tb_bsg_fpu_mul_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TE = 4;
    localparam int CW = $clog2(TE+1);

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_v;
    logic [N-1:0][W-1:0] req_a;
    logic [N-1:0][W-1:0] req_b;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      resp_v;
    logic [W-1:0]      resp_z;
    logic [3:0]        resp_flags;
    logic [N-1:0]      resp_yumi;
    logic              mul_v_o;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_ready;
    logic              mul_v_i;
    logic [W-1:0]      mul_z;
    logic [3:0]        mul_flags;
    logic              mul_yumi;
    logic [CW-1:0]     inflight;

    always #5 clk = ~clk;

    bsg_fpu_mul_arbiter #(.e_p(8), .m_p(23), .num_req_p(N), .tag_els_p(TE)) dut (
        .clk_i(clk), .reset_i(rst),
        .req_v_i(req_v), .req_a_i(req_a), .req_b_i(req_b), .req_ready_and_o(req_ready),
        .resp_v_o(resp_v), .resp_z_o(resp_z), .resp_flags_o(resp_flags), .resp_yumi_i(resp_yumi),
        .mul_v_o(mul_v_o), .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_ready_and_i(mul_ready),
        .mul_v_i(mul_v_i), .mul_z_i(mul_z), .mul_flags_i(mul_flags), .mul_yumi_o(mul_yumi),
        .inflight_o(inflight)
    );

    // Stand-in multiplier: exact for the directed operands, arbitrary but deterministic otherwise.
    function automatic logic [35:0] mock_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        if ((a[30:0] == 31'h7F800000 && b[30:0] == 31'h0) || (b[30:0] == 31'h7F800000 && a[30:0] == 31'h0))
            return {4'b0100, 32'h7FC00000};
        if (a == 32'h3F800000) return {4'b0000, b};
        if (b == 32'h3F800000) return {4'b0000, a};
        return {a[3:0] ^ b[7:4], a + b};
    endfunction

    logic [2:0]   s_v;
    logic [W-1:0] s_z [3];
    logic [3:0]   s_f [3];
    logic [35:0]  mres;

    assign mres      = mock_mul(mul_a, mul_b);
    assign mul_v_i   = s_v[2];
    assign mul_z     = s_z[2];
    assign mul_flags = s_f[2];
    assign mul_ready = ~(s_v[2] & ~mul_yumi);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_v <= '0;
        end else if (mul_ready) begin
            s_v    <= {s_v[1], s_v[0], mul_v_o};
            s_z[2] <= s_z[1]; s_f[2] <= s_f[1];
            s_z[1] <= s_z[0]; s_f[1] <= s_f[0];
            s_z[0] <= mres[31:0]; s_f[0] <= mres[35:32];
        end
    end

    typedef struct {
        int          req;
        logic [31:0] z;
        logic [3:0]  f;
    } exp_t;

    exp_t q[$];
    int   rr = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [N-1:0]  obs_grant, obs_resp;
    logic [W-1:0]  obs_z;
    logic [3:0]    obs_f;
    logic [CW-1:0] obs_infl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One cycle: sample at the falling edge, check against the model, advance the model at the rising edge.
    task automatic step();
        int           g;
        int           idx;
        logic [N-1:0] eg;
        logic [N-1:0] erv;
        logic         ey;
        logic [35:0]  r;
        #4;
        g = -1;
        if (!rst && mul_ready && (|req_v)) begin
            for (int k = 0; k < N; k++) begin
`ifdef BSG_FPU_MUL_ARB_FIXED_PRIO_EN
                idx = k;
`else
                idx = (rr + k) % N;
`endif
                if (g < 0 && req_v[idx]) g = idx;
            end
        end
        eg = (g >= 0) ? N'(1 << g) : '0;
        chk("grant", req_ready, eg);
        chk("mul_v", mul_v_o, g >= 0);
        if (g >= 0) begin
            chk("mul_a", mul_a, req_a[g]);
            chk("mul_b", mul_b, req_b[g]);
        end
        erv = '0;
        ey  = 1'b0;
        if (!rst && mul_v_i) begin
            if (q.size() == 0) begin
                chk("orphan_result", mul_v_i, 0);
            end else begin
                erv = N'(1 << q[0].req);
                ey  = resp_yumi[q[0].req];
                chk("resp_z", resp_z, q[0].z);
                chk("resp_flags", resp_flags, q[0].f);
            end
        end
        chk("resp_v", resp_v, erv);
        chk("mul_yumi", mul_yumi, ey);
        chk("inflight", inflight, q.size());
        chk("inflight_cap", inflight <= 3, 1);
        obs_grant = req_ready;
        obs_resp  = resp_v;
        obs_z     = resp_z;
        obs_f     = resp_flags;
        obs_infl  = inflight;
        @(posedge clk);
        if (rst) begin
            q.delete();
            rr = 0;
        end else begin
            if (ey) void'(q.pop_front());
            if (g >= 0) begin
                r = mock_mul(req_a[g], req_b[g]);
                q.push_back('{g, r[31:0], r[35:32]});
                rr = (g + 1) % N;
            end
        end
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i] = $urandom;
            req_b[i] = $urandom;
        end
    endtask

    task automatic drain(input int n);
        req_v     = '0;
        resp_yumi = '1;
        for (int i = 0; i < n; i++) step();
    endtask

    logic [N-1:0] resp_seq[$];
    int           resp_cnt;

    initial begin
        rst       = 1'b1;
        req_v     = '1;
        resp_yumi = '1;
        rand_ops();
        @(posedge clk); #1;
        step();
        chk("reset_grant", obs_grant, 0);
        chk("reset_inflight", obs_infl, 0);
        chk("reset_resp_v", obs_resp, 0);
        rst = 1'b0;

`ifdef BSG_FPU_MUL_ARB_FIXED_PRIO_EN
        req_v = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            step();
            chk("fixed_prio_grant", obs_grant, 4'b0001);
        end
        drain(6);
`else
        req_v = '1;
        for (int i = 0; i < 12; i++) begin
            if (i == 8) req_v = '0;
            rand_ops();
            step();
            if (i < 8) chk("rr_grant_order", obs_grant, 1 << (i % 4));
            if (obs_resp != '0) resp_seq.push_back(obs_resp);
        end
        chk("rr_resp_count", resp_seq.size(), 8);
        for (int i = 0; i < resp_seq.size() && i < 8; i++)
            chk("rr_resp_order", resp_seq[i], 1 << (i % 4));
        drain(4);
`endif

        // Single op: 1.0 * 2.0 from req0, result exactly 3 cycles after issue.
        req_v = 4'b0001;
        req_a[0] = 32'h3F800000;
        req_b[0] = 32'h40000000;
        step();
        chk("single_issue", obs_grant, 4'b0001);
        req_v = '0;
        step(); chk("single_early1", obs_resp, 0);
        step(); chk("single_early2", obs_resp, 0);
        step();
        chk("single_resp_v", obs_resp, 4'b0001);
        chk("single_resp_z", obs_z, 32'h40000000);
        chk("single_flags", obs_f, 4'b0000);
        drain(2);

        // Backpressure: req2 withholds yumi.
        req_v     = 4'b0100;
        resp_yumi = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            step();
        end
        chk("bp_inflight", obs_infl, 3);
        chk("bp_ready_low", obs_grant, 0);
        req_v     = '0;
        resp_yumi = '1;
        resp_cnt  = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (obs_resp != '0) begin
                resp_cnt++;
                chk("bp_drain_owner", obs_resp, 4'b0100);
            end
        end
        chk("bp_drain_count", resp_cnt, 3);

        // Flag routing: inf * 0 from req3.
        req_v    = 4'b1000;
        req_a[3] = 32'h7F800000;
        req_b[3] = 32'h00000000;
        step();
        chk("flag_issue", obs_grant, 4'b1000);
        req_v = '0;
        step();
        step();
        step();
        chk("flag_resp_v", obs_resp, 4'b1000);
        chk("flag_resp_z", obs_z, 32'h7FC00000);
        chk("flag_flags", obs_f, 4'b0100);
        drain(2);

        // Reset mid-flight, asserted between clock edges.
        req_v = '1;
        rand_ops();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ready", req_ready, 0);
        chk("midrst_mul_v", mul_v_o, 0);
        chk("midrst_resp_v", resp_v, 0);
        chk("midrst_yumi", mul_yumi, 0);
        chk("midrst_inflight", inflight, 0);
        q.delete();
        rr = 0;
        @(posedge clk); #1;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_grant", obs_grant, 4'b0001);
        req_v = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i < 2) chk("post_rst_no_spurious", obs_resp, 0);
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            req_v     = N'($urandom);
            resp_yumi = N'($urandom);
            rand_ops();
            step();
        end
        drain(10);
        chk("final_inflight", inflight, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bsg_fpu_mul_arbiter.md
# bsg_fpu_mul_arbiter

Shares one pipelined FP multiplier (`bsg_fpu_mul`, 3-stage, valid/ready-and issue, valid/yumi result) among `num_req_p` requesters. Each cycle a round-robin arbiter issues one operand pair. A tag FIFO records the issuing requester so that every in-order result and its exception flags return to that requester. The block sits between the lane-level FP request ports and the single multiplier instance; the multiplier's `en_i` is tied high at the parent.

## Interface
- `e_p`, 8: exponent width.
- `m_p`, 23: mantissa width.
- `num_req_p`, 4: number of requesters, at least 2.
- `tag_els_p`, 4: tag FIFO depth; at least 4, which is the multiplier capacity of 3 plus 1.
- `clk_i` in 1: single clock.
- `reset_i` in 1: reset, asynchronous, active-high. Also drives the multiplier's `reset_i`.
- `req_v_i` in `num_req_p`: per-requester operand valid.
- `req_a_i` in `num_req_p` x (`e_p+m_p+1`): operand A per requester.
- `req_b_i` in `num_req_p` x (`e_p+m_p+1`): operand B per requester.
- `req_ready_and_o` out `num_req_p`: one-hot grant; the transfer occurs when `req_v_i & req_ready_and_o`.
- `resp_v_o` out `num_req_p`: result valid, asserted only for the owning requester.
- `resp_z_o` out `e_p+m_p+1`: result, shared by all requesters.
- `resp_flags_o` out 4: {unimplemented, invalid, overflow, underflow}, shared.
- `resp_yumi_i` in `num_req_p`: per-requester result consume.
- `mul_v_o` out 1: issue valid to the multiplier.
- `mul_a_o` out `e_p+m_p+1`: operand A to the multiplier.
- `mul_b_o` out `e_p+m_p+1`: operand B to the multiplier.
- `mul_ready_and_i` in 1: multiplier ready.
- `mul_v_i` in 1: multiplier result valid.
- `mul_z_i` in `e_p+m_p+1`: multiplier result.
- `mul_flags_i` in 4: multiplier exception flags.
- `mul_yumi_o` out 1: consume strobe to the multiplier.
- `inflight_o` out `$clog2(tag_els_p+1)`: current tag FIFO occupancy.

## Operation
- Issue condition: `can_issue = mul_ready_and_i & ~tag_full & ~reset_i`.
- Grant: the first requester with `req_v_i` set, searching from `rr_ptr_r` upward with wrap. The grant is combinational.
- `req_ready_and_o[g] = can_issue` for the winner `g` only; all other bits are 0.
- `mul_v_o = can_issue & |req_v_i`. `mul_a_o`/`mul_b_o` are muxed from the winner and are don't-care when `mul_v_o=0`.
- On an issue (`mul_v_o & mul_ready_and_i`):
  - push `g` into the tag FIFO;
  - set `rr_ptr_r <= (g+1) mod num_req_p`.
- Without an issue, `rr_ptr_r` holds.
- Return path:
  - `t` = tag FIFO head.
  - `resp_v_o = mul_v_i ? (1 << t) : 0`.
  - `resp_z_o = mul_z_i`; `resp_flags_o = mul_flags_i`.
  - `mul_yumi_o = mul_v_i & resp_yumi_i[t]`.
  - The FIFO pops on `mul_yumi_o`.
  - `resp_yumi_i` bits of non-owners are ignored.
- Ordering: the multiplier is in-order, so the FIFO head always matches the result at its output.
- Full FIFO: push is blocked even if a pop happens in the same cycle. This avoids a yumi-to-ready combinational path.
- Simultaneous push and pop when not full: occupancy is unchanged and both operations take effect.
- Protocol errors:
  - `mul_v_i` while the FIFO is empty is illegal; it fires an assertion and `resp_v_o` is held at 0.
  - A push while full is impossible by construction.

## Timing
- Request-to-issue: 0 cycles, combinational through the arbiter.
- Issue-to-result: 3 cycles, the multiplier latency, plus any stall cycles from `resp_yumi_i`.
- Result-to-response: 0 cycles, combinational passthrough.
- Sustained throughput: 1 op/cycle while the owning requesters consume results in the same cycle.
- Asynchronous reset state:
  - `rr_ptr_r = 0`;
  - FIFO empty, so `inflight_o = 0`.
- Outputs while `reset_i` is high: `req_ready_and_o = 0`, `mul_v_o = 0`, `resp_v_o = 0`, `mul_yumi_o = 0`.
- Reset mid-operation: all in-flight tags are discarded. The multiplier clears its valids on the same reset, so no orphan result ever appears. Results lost to reset are not replayed.

## Configuration
- Macro: `BSG_FPU_MUL_ARB_FIXED_PRIO_EN`.
- Defined:
  - fixed priority, lowest index wins;
  - `rr_ptr_r` is removed;
  - starvation of high indices is permitted.
- Undefined (default): round-robin as described in Operation.
- The tag/return path is identical in both builds.

## Structure
- Package `bsg_fpu_mul_arb_pkg` contains:
  - the `fpu_flags_s` struct {unimplemented, invalid, overflow, underflow};
  - the function for tag width, `$clog2(num_req_p)` with a minimum of 1.
- Sub-module `bsg_fpu_mul_arb_tag_fifo`:
  - parameterised width/depth circular buffer;
  - read/write pointers that wrap at `tag_els_p`;
  - an occupancy counter;
  - outputs `full_o` and `empty_o`.

## Test plan
- **Single op:** req0 issues A=0x3F800000, B=0x40000000, with `resp_yumi_i` tied high.
  - `resp_v_o = 4'b0001` with `resp_z_o = 0x40000000` exactly 3 cycles after issue.
  - Flags are 0.
- **Round-robin:** all 4 requesters hold `req_v_i` for 8 cycles.
  - Grant order 0,1,2,3,0,1,2,3.
  - Each response returns to the matching requester, in that order.
- **Backpressure:** req2 holds `resp_yumi_i` low.
  - At most 3 operations are in flight, then `req_ready_and_o = 0`.
  - Releasing yumi drains the results in order.
  - `inflight_o` never exceeds 3.
- **Flag routing:** req3 issues inf*0 (0x7F800000 x 0x00000000).
  - `resp_v_o = 4'b1000`, quiet NaN, `resp_flags_o = 4'b0100`.
- **Reset mid-flight:** 2 operations issued, then `reset_i` asserted asynchronously between edges.
  - All outputs are 0 immediately.
  - After release, `inflight_o = 0`, there is no spurious `resp_v_o`, and the next grant goes to req0.
- **Fixed-priority build:** with `BSG_FPU_MUL_ARB_FIXED_PRIO_EN` defined, req0 and req1 both request continuously.
  - req0 receives every grant.
